// File: rtl/pipe_wall_chain_if.sv
// Valid/ready handshake bundle used at both ends of pipe_wall_chain.
// A word moves on a rising edge when valid and ready are both high.
// The producer holds valid and data stable until that happens.
// The consumer may raise or drop ready in any cycle.
// ready may depend combinationally on valid.
// The master modport drives valid/data; the slave modport drives ready.
interface pipe_wall_chain_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_wall_chain.sv
// pipe_wall_chain: DEPTH register walls carrying a WIDTH-bit payload.
// Each stage has its own valid bit and can be flushed on its own.
// Backpressure collapses bubbles: a stalled head only blocks upstream
// stages once every slot between them is full.
// Optional statistics counters are enabled by defining PIPE_WALL_CHAIN_STATS_EN.
module pipe_wall_chain #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 3,
    parameter int ZERO_BUBBLE = 1,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_wall_chain_if.slave  in_if,
    pipe_wall_chain_if.master out_if,
    input  logic [DEPTH-1:0]  flush,
    output logic [CW-1:0]     occupancy
`ifdef PIPE_WALL_CHAIN_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       kill_count
`endif
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] src_v;
    logic [DEPTH:0]   rdy;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] d_nxt [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];

    function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] bits);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + CW'(bits[i]);
        end
        return n;
    endfunction

    assign live          = v & ~flush;
    assign in_if.ready   = rdy[0];
    assign out_if.valid  = live[DEPTH-1];
    // With zero-bubble payloads, a killed head must not show stale data.
    assign out_if.data   = (ZERO_BUBBLE != 0 && !live[DEPTH-1]) ? '0 : d[DEPTH-1];

    // Ready ripples from the output toward the input.
    // An empty or killed slot always frees the stage feeding it.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_if.ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = ~v[i] | flush[i] | rdy[i+1];
        end
    end

    // Next valid/payload per stage. A loaded stage takes its source's live bit.
    // A held stage that is flushed turns invalid.
    always_comb begin
        src_v[0] = in_if.valid;
        src_d[0] = in_if.data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = live[i-1];
            src_d[i] = d[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            v_nxt[i] = rdy[i] ? src_v[i] : live[i];
            if (rdy[i] && src_v[i]) begin
                d_nxt[i] = src_d[i];
            end else if (ZERO_BUBBLE != 0 && !v_nxt[i]) begin
                d_nxt[i] = '0;
            end else begin
                d_nxt[i] = d[i];
            end
        end
    end

    // Stage registers. Occupancy is the popcount of the next valid vector,
    // so it always tracks the valid bits exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v         <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else begin
            v         <= v_nxt;
            occupancy <= popcount(v_nxt);
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= d_nxt[i];
            end
        end
    end

`ifdef PIPE_WALL_CHAIN_STATS_EN
    logic [CW-1:0] kills;
    logic [32:0]   kill_sum;

    assign kills    = popcount(v & flush);
    assign kill_sum = {1'b0, kill_count} + 33'(kills);

    // Saturating stall and kill counters. A clear wins over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            kill_count   <= '0;
        end else if (stats_clr) begin
            stall_cycles <= '0;
            kill_count   <= '0;
        end else begin
            if (in_if.valid && !in_if.ready && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            kill_count <= kill_sum[32] ? 32'hFFFF_FFFF : kill_sum[31:0];
        end
    end
`endif

endmodule

// File: doc/pipe_wall_chain.md
Name: pipe_wall_chain

Overview:
- Parametrised successor to the fixed per-stage register walls between pipeline stages.
- Chain of DEPTH register walls carrying a WIDTH-bit payload, with a per-stage valid bit and valid/ready handshakes at both ends.
- Per-stage flush (kill) and bubble-collapsing backpressure: a stalled head does not block upstream stages while empty slots remain.
- Used between CPU pipeline stages and as a generic retiming/buffer chain in datapaths.

Parameters:
- WIDTH, 32: payload width in bits, >=1.
- DEPTH, 3: number of register stages, >=1. Stage 0 is the input side; stage DEPTH-1 drives the output.
- ZERO_BUBBLE, 1: 1 = payload of an invalid or killed slot is forced to 0; 0 = payload of an invalid slot is don't-care and holds its old value.
- CW, $clog2(DEPTH+1): occupancy counter width (derived; not to be overridden).

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: upstream offers in_data.
- in_data, input, WIDTH: upstream payload.
- in_ready, output, 1: stage 0 can accept this cycle (combinational).
- out_valid, output, 1: stage DEPTH-1 holds a live entry (combinational).
- out_data, output, WIDTH: stage DEPTH-1 payload.
- out_ready, input, 1: downstream accepts.
- flush, input, DEPTH: bit i kills the entry currently in stage i.
- occupancy, output, CW: number of valid stages (registered).

Behaviour:
- Reset: while rst_n=0, all valid bits, all payload registers and occupancy are 0 (asynchronous assertion). Resulting outputs: out_valid=0, in_ready=1, out_data=0.
- Live entry: stage i is live when v[i] & ~flush[i].
- Ready chain (combinational): rdy[DEPTH]=out_ready; rdy[i] = ~v[i] | flush[i] | rdy[i+1]; in_ready = rdy[0].
- Stage update: stage i loads from stage i-1 (or from input for i=0) when rdy[i]=1; otherwise it holds.
- Loaded valid: valid of the loaded value = source live bit. For the input, that is in_valid.
- Killed entries: an entry flushed while moving arrives invalid; a flushed entry that holds becomes invalid. A killed entry never reaches the output.
- Output: out_valid = v[DEPTH-1] & ~flush[DEPTH-1]. A transfer occurs when out_valid & out_ready; out_valid drops or advances on the next edge.
- Input: a transfer occurs when in_valid & in_ready. The input side has no flush; upstream kills by deasserting in_valid.
- Latency: an entry accepted at edge n is first visible at the output after edge n+DEPTH-1 if never stalled. Zero-bubble throughput is 1 entry/cycle.
- Order: payload order is strictly preserved; no reordering or duplication.
- Simultaneous push and pop on a full chain with out_ready=1: accepted, occupancy unchanged.
- Flush of every stage plus in_valid in the same cycle: the chain contains only the new entry; occupancy = 1.
- occupancy: next value = popcount of the next valid vector. It must always equal the popcount of the valid bits; no separate inc/dec arithmetic is permitted.
- Reset mid-operation: all entries are discarded immediately; no output transfer is reported during reset.
- ZERO_BUBBLE=1: any slot written with valid=0 gets payload 0, so out_data=0 whenever out_valid=0.

Optional Feature:
- Macro: PIPE_WALL_CHAIN_STATS_EN.
- Defined — adds these ports:
  - stats_clr, input, 1.
  - stall_cycles, output, 32: counts cycles with in_valid & ~in_ready.
  - kill_count, output, 32: adds the number of live-before-flush entries killed each cycle (popcount of v & flush).
- Defined — counter rules: both counters saturate at 32'hFFFFFFFF, are reset to 0 by rst_n, and are cleared synchronously by stats_clr. stats_clr has priority over increment in the same cycle.
- Undefined: these ports and counters do not exist; core behaviour is identical.

Test Plan (WIDTH=8, DEPTH=3, ZERO_BUBBLE=1):
- Reset: assert rst_n=0 mid-stream with 2 live entries -> out_valid=0, occupancy=0, in_ready=1, out_data=8'h00 immediately and after release.
- Streaming: out_ready=1; push 8'h11, 8'h22, 8'h33 on consecutive edges starting at edge 0 -> out_data=11/22/33 valid after edges 2/3/4; occupancy holds at 3 with continuous flow.
- Bubble collapse: out_ready=0; push 8'hA1, idle one cycle, push 8'hA2, 8'hA3 -> in_ready stays 1 until occupancy=3, then in_ready=0. Head=A1; pop order is A1, A2, A3.
- Mid-stage flush under stall: chain full {head C, B, A}, out_ready=0, flush=3'b010 for one cycle -> occupancy=2; in_ready=1 that same cycle. Output order is C then A.
- Head flush: out_valid=1 with head 8'h5C, out_ready=1, flush=3'b100 -> out_valid=0 that cycle, no transfer counted, 5C never appears.
- Stats (macro defined): 4 stalled cycles, then a flush of 2 live entries, then stats_clr pulse -> stall_cycles=4, kill_count=2, then both 0 the cycle after the clear.
